// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

    localparam int          FETCH_PC_W = 14;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam int          PC_INC     = 4;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO of fetch entries (PC + instruction) with flush.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  data_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction fetch: PC, IMEM requests, epoch-tagged response capture, decode queue.
// Optional misaligned-redirect trap enabled by IFETCH_MISALIGN_CHK_EN.
module inst_fetch
    import ifetch_pkg::*;
#(
    parameter int             PC_W     = FETCH_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int             Q_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clkEn,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [PC_W-1:0] dec_pc
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic            fetch_fault
`endif
);

    localparam int CW = $clog2(Q_DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, req_pc_q;
    logic            inflight_q, epoch_q, req_epoch_q;
    fetch_entry_t    last_q, head, push_entry;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_empty, fifo_full;
    logic            pop, push, credit_ok, misalign;
    logic [PC_W-1:0] redir_pc;
    logic            unused_lsb;

    assign redir_pc   = {redirect_pc[PC_W-1:2], 2'b00};
    assign unused_lsb = ^redirect_pc[1:0];
`ifdef IFETCH_MISALIGN_CHK_EN
    logic fault_q;
    assign misalign    = redirect_valid & (|redirect_pc[1:0]);
    assign fetch_fault = fault_q;
    always_ff @(posedge clk) begin
        if (rst)                 fault_q <= 1'b0;
        else if (redirect_valid) fault_q <= misalign;
    end
`else
    assign misalign = 1'b0;
`endif

    assign pop       = dec_valid & dec_ready;
    // Count the in-flight read as already occupying a slot so the capture can never overflow.
    assign credit_ok = (int'(fifo_cnt) + int'(inflight_q) - int'(pop)) < Q_DEPTH;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
        if (redirect_valid) state_d = misalign ? S_HALT : S_RUN;
    end

    always_comb begin
        imem_req  = ~rst & (state_q == S_RUN) & clkEn & ~redirect_valid & credit_ok;
        imem_addr = pc_q;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redir_pc;
        else if (imem_req)  pc_d = pc_q + PC_W'(PC_INC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
            req_pc_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= imem_req;
            if (redirect_valid) epoch_q <= ~epoch_q;
            if (imem_req) begin
                req_pc_q    <= pc_q;
                req_epoch_q <= epoch_q;
            end
        end
    end

    // A response landing in a redirect cycle belongs to the old stream and is dropped.
    assign push       = inflight_q & (req_epoch_q == epoch_q) & ~redirect_valid;
    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

    fetch_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_o  (head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && fifo_full && !pop));
    end

    // Decode outputs hold the last presented entry once the queue drains.
    always_ff @(posedge clk) begin
        if (rst)              last_q <= '{pc: '0, instr: NOP_INSTR};
        else if (!fifo_empty) last_q <= head;
    end

    assign dec_valid = ~fifo_empty;
    assign dec_instr = fifo_empty ? last_q.instr : head.instr;
    assign dec_pc    = fifo_empty ? last_q.pc    : head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; IMEM model returns the byte address as data.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, clkEn, imem_req, redirect_valid, dec_valid, dec_ready;
    logic [13:0] imem_addr, redirect_pc, dec_pc;
    logic [31:0] imem_rdata, dec_instr;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        fetch_fault;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n10   = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .clkEn          (clkEn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    always @(posedge clk) if (imem_req) imem_rdata <= {18'b0, imem_addr};

    always @(negedge clk)
        if (!rst && dec_valid && dec_ready && dec_pc == 14'h0010) n10++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Leaves the bench in cycle 0: the first cycle with rst low.
    task automatic do_reset();
        rst = 1'b1; clkEn = 1'b1; dec_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        rst = 1'b0; n10 = 0;
        settle();
    endtask

    task automatic redirect(input logic [13:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc; settle();
    endtask

    task automatic unredirect();
        redirect_valid = 1'b0; settle();
    endtask

    initial begin
        imem_rdata = '0;

        // boot and streaming
        do_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", dec_valid, 0);
        chk("rst_instr", dec_instr, 32'h00000013);
        chk("rst_pc", dec_pc, 0);
        tick(); chk("c1_req", imem_req, 1); chk("c1_addr", imem_addr, 14'h0000);
        tick(); chk("c2_addr", imem_addr, 14'h0004); chk("c2_valid", dec_valid, 0);
        tick(); chk("c3_valid", dec_valid, 1); chk("c3_pc", dec_pc, 14'h0000);
        chk("c3_instr", dec_instr, 32'h0);
        tick(); chk("c4_pc", dec_pc, 14'h0004);
        tick(); chk("c5_pc", dec_pc, 14'h0008);

        // backpressure
        dec_ready = 1'b0; settle();
        chk("bp_req5", imem_req, 0);
        for (int i = 6; i <= 9; i++) begin
            tick();
            chk("bp_req", imem_req, 0);
            chk("bp_valid", dec_valid, 1);
            chk("bp_pc", dec_pc, 14'h0008);
        end
        tick(); dec_ready = 1'b1; settle();
        chk("rel_pc8", dec_pc, 14'h0008);
        chk("rel_req", imem_req, 1); chk("rel_addr", imem_addr, 14'h0010);
        tick(); chk("rel_pcC", dec_pc, 14'h000C);
        tick(); chk("rel_pc10", dec_pc, 14'h0010);
        tick(); chk("rel_pc14", dec_pc, 14'h0014);

        // redirect with 0x000C in flight
        do_reset();
        repeat (4) tick();
        chk("rd_addrC", imem_addr, 14'h000C);
        tick(); redirect(14'h0100);
        chk("rd_req0", imem_req, 0); chk("rd_head", dec_pc, 14'h0008);
        tick(); unredirect();
        chk("rd_v6", dec_valid, 0); chk("rd_addr", imem_addr, 14'h0100);
        tick(); chk("rd_v7", dec_valid, 0);
        tick(); chk("rd_v8", dec_valid, 1); chk("rd_pc8", dec_pc, 14'h0100);
        tick(); chk("rd_pc9", dec_pc, 14'h0104);

        // redirect plus pop
        do_reset();
        repeat (7) tick();
        chk("rp_head", dec_pc, 14'h0010);
        redirect(14'h0200);
        tick(); unredirect(); chk("rp_empty", dec_valid, 0);
        tick(); chk("rp_v9", dec_valid, 0);
        tick(); chk("rp_pc10", dec_pc, 14'h0200); chk("rp_v10", dec_valid, 1);
        tick(); chk("rp_pc11", dec_pc, 14'h0204);
        chk("rp_once", n10, 1);

        // wrap-around
        do_reset();
        repeat (3) tick();
        redirect(14'h3FF8);
        tick(); unredirect(); chk("wr_a4", imem_addr, 14'h3FF8);
        tick(); chk("wr_a5", imem_addr, 14'h3FFC);
        tick(); chk("wr_a6", imem_addr, 14'h0000);
        chk("wr_pc6", dec_pc, 14'h3FF8); chk("wr_in6", dec_instr, 32'h3FF8);
        tick(); chk("wr_pc7", dec_pc, 14'h3FFC);
        tick(); chk("wr_pc8", dec_pc, 14'h0000);

        // misaligned redirect
        do_reset();
        repeat (3) tick();
        redirect(14'h0102);
`ifdef IFETCH_MISALIGN_CHK_EN
        tick(); unredirect();
        chk("ma_fault", fetch_fault, 1); chk("ma_req", imem_req, 0);
        for (int i = 5; i <= 6; i++) begin
            tick();
            chk("ma_hold_f", fetch_fault, 1); chk("ma_hold_r", imem_req, 0);
            chk("ma_hold_v", dec_valid, 0);
        end
        tick(); redirect(14'h0104);
        chk("ma_f7", fetch_fault, 1); chk("ma_r7", imem_req, 0);
        tick(); unredirect();
        chk("ma_clr", fetch_fault, 0); chk("ma_req8", imem_req, 1);
        chk("ma_addr8", imem_addr, 14'h0104);
        tick(); tick(); chk("ma_pc", dec_pc, 14'h0104); chk("ma_v", dec_valid, 1);
`else
        tick(); unredirect();
        chk("ma_req", imem_req, 1); chk("ma_addr", imem_addr, 14'h0100);
        tick(); tick(); chk("ma_pc", dec_pc, 14'h0100); chk("ma_v", dec_valid, 1);
`endif

        // fetch enable gating
        do_reset();
        tick(); clkEn = 1'b0; settle();
        chk("en_off", imem_req, 0);
        clkEn = 1'b1; settle();
        chk("en_on", imem_req, 1); chk("en_addr", imem_addr, 14'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage of the RV32I core, directly upstream of inst_dec. It owns the program counter and issues word reads to synchronous instruction memory (IMEM). Returned instructions are buffered with their PC in a small queue and presented to decode over a valid/ready handshake. Redirects from the branch/jump resolution logic flush the stage and restart fetch at the target address.

Parameters:
- PC_W, 14, PC/byte-address width; matches the 14-bit pc of the core.
- RESET_PC, 14'h0000, first fetch address after reset; must be word aligned.
- Q_DEPTH, 2, fetch queue entries; legal values 2..4.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high (already decided)
- clkEn  in  1  fetch enable; when 0, no new IMEM request is issued
- imem_req  out  1  IMEM read strobe
- imem_addr  out  PC_W  IMEM byte address; bits [1:0] are always 00
- imem_rdata  in  32  IMEM read data; valid exactly 1 cycle after imem_req
- redirect_valid  in  1  flush-and-redirect pulse
- redirect_pc  in  PC_W  redirect target address
- dec_valid  out  1  queue head is valid
- dec_ready  in  1  decode accepts the head
- dec_instr  out  32  head instruction; drives inst_dec.instruction_in
- dec_pc  out  PC_W  PC of the head instruction
- fetch_fault  out  1  misaligned redirect flag (present only with the optional feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - outputs: imem_req=0, dec_valid=0, dec_instr=32'h00000013 (NOP), dec_pc=0, fetch_fault=0;
  - state: pc=RESET_PC, queue empty, in-flight=0, epoch=0, FSM=S_BOOT.
  - rst has priority over all other inputs.
- FSM states:
  - S_BOOT: lasts one cycle, no request; moves to S_RUN.
  - S_RUN: normal fetch.
  - S_HALT: entered only via the optional feature; exited only by a valid redirect or rst.
- Issue rule, evaluated in S_RUN:
  - imem_req = clkEn & !redirect_valid & (count + inflight - pop < Q_DEPTH), where pop = dec_valid & dec_ready.
  - On issue: imem_addr=pc, pc<=pc+4, inflight<=1, and the request's epoch and pc are recorded.
  - This sustains 1 instruction per cycle while dec_ready=1.
- Response capture:
  - The cycle after issue, imem_rdata is written into the queue as {recorded pc, rdata}, provided its epoch equals the current epoch.
  - Stale-epoch responses are discarded.
  - Capture happens regardless of clkEn. Space is guaranteed by the credit rule above; the queue never overflows.
- Latency: request at cycle N -> data at N+1 -> dec_valid at N+2. After rst is released at cycle 0: first request at cycle 1, dec_valid at cycle 3.
- Handshake:
  - The head pops when dec_valid & dec_ready.
  - While dec_valid=1 and dec_ready=0, dec_instr and dec_pc stay stable.
  - When the queue is empty, dec_valid=0 and dec_instr/dec_pc hold their last values.
- Redirect (redirect_valid=1):
  - pc<=redirect_pc with bits [1:0] cleared, the queue is flushed, epoch toggles, and no request is issued that cycle.
  - A pop in the same cycle still counts as accepted by decode.
  - A response arriving in the same cycle is dropped.
  - dec_valid is 0 in the next cycle. The first post-redirect instruction appears 3 cycles after the redirect cycle.
- Wrap-around: pc+4 wraps modulo 2^PC_W (14'h3FFC -> 14'h0000) with no flag.
- Simultaneous push and pop on a full queue is legal; count is unchanged.

Optional Feature:
Macro IFETCH_MISALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky), flushes the queue and enters S_HALT (no requests).
  - A later aligned redirect clears fetch_fault and resumes fetch in S_RUN; rst also clears it.
- Undefined:
  - The fetch_fault port is absent, and redirect_pc[1:0] is silently forced to 00.
  - S_HALT is unreachable.

Decomposition:
- Package ifetch_pkg:
  - fetch_entry_t struct {pc[PC_W-1:0], instr[31:0]};
  - fetch_state_e enum {S_BOOT, S_RUN, S_HALT};
  - constants NOP_INSTR=32'h00000013 and PC_INC=4.
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full. inst_fetch keeps the PC, FSM, epoch and credit logic.

Test Plan:
- Reset/boot: release rst at cycle 0, IMEM model returns addr as data, dec_ready=1 -> imem_req at cycle 1 with addr 0x0000; dec_valid at cycle 3 with dec_pc 0x0000; then consecutive PCs 0x0004, 0x0008 every cycle.
- Backpressure: hold dec_ready=0 for 5 cycles -> queue fills to 2, imem_req drops to 0, dec_pc frozen at 0x0008; on release, no instruction is lost or duplicated.
- Redirect with an in-flight response: redirect_pc=0x0100 while a read of 0x000C is in flight -> 0x000C is never presented; dec_pc=0x0100 appears 3 cycles after the redirect.
- Redirect plus pop in the same cycle: head 0x0010 accepted and redirect to 0x0200 in one cycle -> 0x0010 consumed exactly once, queue empty next cycle, next dec_pc=0x0200.
- Wrap-around: redirect to 0x3FF8 -> dec_pc sequence 0x3FF8, 0x3FFC, 0x0000.
- IFETCH_MISALIGN_CHK_EN: redirect_pc=0x0102 -> fetch_fault=1 and imem_req=0 until redirect 0x0104; then fetch_fault=0 and dec_pc=0x0104. Without the macro, the same redirect fetches from 0x0100.
